// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared constants for the bit-serial arithmetic blocks
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT,
        ST_DONE  = S_DONE
    } serial_state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor, x - y - bin
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial LSB-first subtractor with start/ready/done handshake
module serial_sub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] d,
    output logic             b_out,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    serial_state_t state, state_next;

    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] result;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             bit_diff;
    logic             bit_bout;

    full_subtractor u_fs (
        .x    (shift_a[0]),
        .y    (shift_b[0]),
        .bin  (borrow),
        .diff (bit_diff),
        .bout (bit_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (cnt == CNT_W'(WIDTH - 1)) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign ready = (state == ST_IDLE);
    assign busy  = (state == ST_SHIFT);

    // Result bits enter at the MSB so that after WIDTH shifts the LSB sits at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_a <= '0;
            shift_b <= '0;
            result  <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            d       <= '0;
            b_out   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift_a <= a;
                        shift_b <= b;
                        borrow  <= b_in;
                        cnt     <= '0;
                    end
                end
                ST_SHIFT: begin
                    result  <= {bit_diff, result[WIDTH-1:1]};
                    shift_a <= shift_a >> 1;
                    shift_b <= shift_b >> 1;
                    borrow  <= bit_bout;
                    cnt     <= cnt + CNT_W'(1);
                end
                ST_DONE: begin
                    d     <= result;
                    b_out <= borrow;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - directed and swept checks of serial_sub at WIDTH=4 and WIDTH=8
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       bin4 = 1'b0;
    logic       ready4, busy4, bout4, done4;
    logic [3:0] d4;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       bin8 = 1'b0;
    logic       ready8, busy8, bout8, done8;
    logic [7:0] d8;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .b_in(bin4),
        .ready(ready4), .busy(busy4), .d(d4), .b_out(bout4), .done(done4)
    );

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .b_in(bin8),
        .ready(ready8), .busy(busy8), .d(d8), .b_out(bout8), .done(done8)
    );

    // Launches one 4-bit operation; lat = edges from acceptance to done, -1 on timeout.
    task automatic run4(input logic [3:0] ai, input logic [3:0] bi, input logic bini,
                        output int lat, output int rlow, output logic [3:0] d_prev);
        @(negedge clk);
        a4 = ai; b4 = bi; bin4 = bini; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0; a4 = ~ai; b4 = ~bi; bin4 = ~bini;
        lat = -1; rlow = 0; d_prev = d4;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done4) begin
                lat = k;
                break;
            end
            if (!ready4) rlow++;
            d_prev = d4;
            @(posedge clk);
        end
    endtask

    task automatic run8(input logic [7:0] ai, input logic [7:0] bi, input logic bini,
                        output int lat);
        @(negedge clk);
        a8 = ai; b8 = bi; bin8 = bini; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0; a8 = ~ai; b8 = ~bi; bin8 = ~bini;
        lat = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done8) begin
                lat = k;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (ready4 !== 1'b1) $display("FAIL reset_ready got %b expected 1", ready4); else passed++;
        total++; if (busy4 !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy4); else passed++;
        total++; if (done4 !== 1'b0) $display("FAIL reset_done got %b expected 0", done4); else passed++;
        total++; if ({bout4, d4} !== 5'h00) $display("FAIL reset_result got %h expected 00", {bout4, d4}); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, rlow;
        logic [3:0] dp;
        run4(4'b1011, 4'b1100, 1'b0, lat, rlow, dp);
        total++; if (lat !== 5) $display("FAIL basic_latency got %0d expected 5", lat); else passed++;
        total++; if (d4 !== 4'b1111) $display("FAIL basic_d got %b expected 1111", d4); else passed++;
        total++; if (bout4 !== 1'b1) $display("FAIL basic_bout got %b expected 1", bout4); else passed++;
        @(negedge clk);
        total++; if (done4 !== 1'b0) $display("FAIL basic_done_pulse got %b expected 0", done4); else passed++;
    endtask

    task automatic test_ready();
        int lat, rlow;
        logic [3:0] dp;
        run4(4'b1111, 4'b0101, 1'b0, lat, rlow, dp);
        total++; if (d4 !== 4'b1010) $display("FAIL ready_d got %b expected 1010", d4); else passed++;
        total++; if (bout4 !== 1'b0) $display("FAIL ready_bout got %b expected 0", bout4); else passed++;
        total++; if (rlow !== 5) $display("FAIL ready_low_cycles got %0d expected 5", rlow); else passed++;
        total++; if (ready4 !== 1'b1) $display("FAIL ready_at_done got %b expected 1", ready4); else passed++;
    endtask

    task automatic test_back_to_back();
        int lat, rlow;
        logic [3:0] dp;
        run4(4'b0000, 4'b0000, 1'b1, lat, rlow, dp);
        total++; if ({bout4, d4} !== 5'b11111) $display("FAIL b2b_first got %b expected 11111", {bout4, d4}); else passed++;
        run4(4'b0110, 4'b0110, 1'b0, lat, rlow, dp);
        total++; if (dp !== 4'b1111) $display("FAIL b2b_hold got %b expected 1111", dp); else passed++;
        total++; if ({bout4, d4} !== 5'b00000) $display("FAIL b2b_second got %b expected 00000", {bout4, d4}); else passed++;
        total++; if (lat !== 5) $display("FAIL b2b_latency got %0d expected 5", lat); else passed++;
    endtask

    task automatic test_ignore_busy();
        int dones = 0;
        @(negedge clk);
        a4 = 4'b0101; b4 = 4'b0011; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a4 = 4'b1111; b4 = 4'b0000; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done4) dones++;
        end
        total++; if (dones !== 1) $display("FAIL ignore_done_count got %0d expected 1", dones); else passed++;
        total++; if ({bout4, d4} !== 5'b00010) $display("FAIL ignore_result got %b expected 00010", {bout4, d4}); else passed++;
    endtask

    task automatic test_reset_mid();
        int lat, rlow, dones = 0;
        logic [3:0] dp;
        @(negedge clk);
        a4 = 4'b0011; b4 = 4'b0101; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({bout4, d4} !== 5'b00000) $display("FAIL midrst_result got %b expected 00000", {bout4, d4}); else passed++;
        total++; if ({ready4, busy4, done4} !== 3'b100) $display("FAIL midrst_ctrl got %b expected 100", {ready4, busy4, done4}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done4) dones++;
        end
        total++; if (dones !== 0) $display("FAIL midrst_no_done got %0d expected 0", dones); else passed++;
        run4(4'b1001, 4'b0100, 1'b0, lat, rlow, dp);
        total++; if ({bout4, d4} !== 5'b00101) $display("FAIL midrst_fresh got %b expected 00101", {bout4, d4}); else passed++;
    endtask

    task automatic test_width8();
        int lat;
        logic [7:0] av [6] = '{8'd0, 8'd255, 8'd128, 8'd17, 8'd0, 8'd99};
        logic [7:0] bv [6] = '{8'd255, 8'd255, 8'd127, 8'd17, 8'd0, 8'd100};
        logic       cv [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] ai, bi, sum;
        logic       ci, exp_b;
        run8(8'd200, 8'd55, 1'b0, lat);
        total++; if (lat !== 9) $display("FAIL w8_latency got %0d expected 9", lat); else passed++;
        total++; if ({bout8, d8} !== 9'd145) $display("FAIL w8_result got %0d expected 145", {bout8, d8}); else passed++;
        for (int i = 0; i < 14; i++) begin
            if (i < 6) begin
                ai = av[i]; bi = bv[i]; ci = cv[i];
            end else begin
                ai = 8'($urandom_range(0, 255));
                bi = 8'($urandom_range(0, 255));
                ci = 1'($urandom_range(0, 1));
            end
            run8(ai, bi, ci, lat);
            sum = d8 + bi + {7'd0, ci};
            exp_b = ({1'b0, ai} < ({1'b0, bi} + {8'd0, ci}));
            total++;
            if (lat !== 9 || sum !== ai || bout8 !== exp_b)
                $display("FAIL w8_sweep a=%0d b=%0d bin=%0d got d=%0d bout=%b lat=%0d expected a=d+b+bin bout=%b lat=9",
                         ai, bi, ci, d8, bout8, lat, exp_b);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_width8();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
